pio_edge_debounce: RTL and testbench
====================================

# pio_edge_debounce

Parametrised Avalon-MM parallel input port for push-buttons and switches. It synchronises a WIDTH-bit asynchronous input bus and debounces each channel independently. It detects rising and/or falling edges per channel under software control, latches them in a per-bit write-1-to-clear capture register, and raises a level interrupt through a per-bit mask. It sits on the Nios system interconnect as a slave next to the existing input PIOs.

## Interface
- WIDTH, 4: number of input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, 2..4.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles an input must disagree with its stable value before the change is accepted. 0 or 1 means no filtering.
- IRQ_MASK_RESET, 0: reset value of irq_mask, WIDTH bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write happens when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous button/switch inputs.
- irq  out  1  level interrupt.

## Operation
Register map (word addresses). Unlisted addresses read 0 and ignore writes.
- 0 DATA (RO): debounced stable value.
- 1 RAW (RO): synchroniser output, before debounce.
- 2 IRQ_MASK (RW).
- 3 EDGE_CAPTURE (R/W1C): writing 1 to a bit clears that bit; writing 0 has no effect.
- 4 RISE_EN (RW, reset all 1s): enables rising-edge capture per channel.
- 5 FALL_EN (RW, reset 0): enables falling-edge capture per channel.

Per-channel pipeline:
- sync: SYNC_STAGES-deep flop chain; reset value 0.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets cnt and is never accepted.
  - When DEBOUNCE_CYCLES ≤ 1: stable <= sync every cycle.
- prev <= stable every cycle.
- rise = stable & ~prev & RISE_EN; fall = ~stable & prev & FALL_EN.
- Capture update:
  - If (rise | fall) on a bit, that capture bit is set.
  - Otherwise, a W1C write with a 1 in that bit clears it.
  - Simultaneous set and clear on the same bit: set wins, so no edge is lost.
- Changing RISE_EN/FALL_EN does not alter existing capture bits.
- irq = |(EDGE_CAPTURE & IRQ_MASK). It is a combinational OR of flop outputs only.

Reset (asynchronous, active-high):
- sync, stable, prev, cnt, EDGE_CAPTURE, FALL_EN <= 0.
- RISE_EN <= all 1s.
- IRQ_MASK <= IRQ_MASK_RESET.
- readdata <= 0.
- irq is therefore 0 unless the reset values produce a captured edge, which they cannot.
- Reset asserted mid-debounce discards the count; a channel held high through reset release is treated as a fresh rising edge (stable goes 0→1 after filtering).

## Timing
- readdata <= mux(address) on every clk edge, regardless of chipselect. Read latency is 1 cycle; no wait states. Writes take effect at the edge where chipselect & ~write_n is sampled.
- in_port change settles before edge k:
  - RAW reflects it after edge k+SYNC_STAGES-1.
  - stable/DATA changes at edge k+SYNC_STAGES+max(DEBOUNCE_CYCLES,1)-1.
  - The capture bit and irq assert at the following edge.
- W1C write at edge j: the capture bit is 0 after edge j and irq falls after edge j, unless a new edge is detected at j.
- IRQ_MASK write: irq follows the new mask combinationally after the write edge.
- The counter never wraps: it is bounded by DEBOUNCE_CYCLES-1.

## Test plan
Bench configuration: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: reset=1 with random in_port -> readdata=0, irq=0. After release, a read of addr 4 returns 0xF and addr 5 returns 0x0.
- Clean press: in_port[0] 0→1 before edge k, IRQ_MASK=0x1 -> DATA bit0=1 after edge k+5, EDGE_CAPTURE=0x1 and irq=1 after edge k+6.
- Glitch rejection: in_port[1] high for 3 cycles then low -> DATA, RAW-settled and EDGE_CAPTURE stay 0. A 4-cycle pulse is accepted.
- Falling only: RISE_EN=0, FALL_EN=0x4, toggle in_port[2] 0→1→0 (each held 10 cycles) -> EDGE_CAPTURE=0x4 only after the release.
- W1C: capture=0xB, write 0x2 to addr 3 -> capture=0x9. Write 0x9 -> 0x0 and irq=0.
- Simultaneous set/clear: W1C of bit3 on the same edge as a new bit3 edge -> bit3 remains 1 and irq stays high. Also assert reset mid-debounce -> cnt is discarded and no capture occurs.

Source files
------------

// File: rtl/pio_edge_debounce.sv
// Avalon-MM parallel input port: per-channel synchroniser, debounce filter,
// programmable edge capture (W1C) and masked level interrupt.
module pio_edge_debounce #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] capture_q;
    logic [WIDTH-1:0] capture_d;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES <= 1) begin : g_no_filter
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable_q <= '0;
            end else begin
                stable_q <= raw;
            end
        end
    end else begin : g_filter
        localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

        logic [CntW-1:0] cnt_q [WIDTH];

        // Any cycle where the input agrees with the stable value restarts the count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable_q <= '0;
                for (int ch = 0; ch < int'(WIDTH); ch++) begin
                    cnt_q[ch] <= '0;
                end
            end else begin
                for (int ch = 0; ch < int'(WIDTH); ch++) begin
                    if (raw[ch] == stable_q[ch]) begin
                        cnt_q[ch] <= '0;
                    end else if (cnt_q[ch] == CntMax) begin
                        stable_q[ch] <= raw[ch];
                        cnt_q[ch]    <= '0;
                    end else begin
                        cnt_q[ch] <= cnt_q[ch] + 1'b1;
                    end
                end
            end
        end
    end

    assign edge_det = (stable_q & ~prev_q & rise_en_q) | (~stable_q & prev_q & fall_en_q);

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign w1c_mask     = (wr_en && address == 3'd3) ? wdata : '0;

    // A newly detected edge overrides a same-cycle clear so no event is lost.
    assign capture_d = (capture_q & ~w1c_mask) | edge_det;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[WIDTH-1:0] = stable_q;
            3'd1:    readdata_d[WIDTH-1:0] = raw;
            3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata_d[WIDTH-1:0] = capture_q;
            3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
            3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            capture_q  <= '0;
            irq_mask_q <= IRQ_MASK_RESET;
            rise_en_q  <= '1;
            fall_en_q  <= '0;
            readdata   <= '0;
        end else begin
            prev_q    <= stable_q;
            capture_q <= capture_d;
            readdata  <= readdata_d;
            if (wr_en) begin
                case (address)
                    3'd2:    irq_mask_q <= wdata;
                    3'd4:    rise_en_q  <= wdata;
                    3'd5:    fall_en_q  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign irq = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_debounce.sv
// Directed bench for pio_edge_debounce: register access, debounce timing,
// glitch rejection, edge selection, W1C behaviour and reset handling.
module tb_pio_edge_debounce;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;
    logic [31:0]      rd;

    int n_checks = 0;
    int n_pass   = 0;

    pio_edge_debounce #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .IRQ_MASK_RESET (4'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'($urandom);
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        in_port = 4'h0;
        tick(1);
        reset = 1'b0;
        tick(1);

        reg_read(3'd4, rd); check("rise_en_reset", rd, 32'hF);
        reg_read(3'd5, rd); check("fall_en_reset", rd, 32'h0);
        reg_read(3'd2, rd); check("irq_mask_reset", rd, 32'h0);
        reg_read(3'd3, rd); check("capture_reset", rd, 32'h0);
        reg_write(3'd6, 32'hFFFF_FFFF);
        reg_read(3'd6, rd); check("unmapped_read", rd, 32'h0);

        // Clean press: input settles before edge k, DATA at k+5, capture/irq at k+6.
        reg_write(3'd2, 32'h1);
        address = 3'd0;
        in_port = 4'h1;
        tick(5);
        check("press_irq_k4", {31'b0, irq}, 32'h0);
        tick(1);
        check("press_data_k5_readback", readdata, 32'h0);
        check("press_irq_k5", {31'b0, irq}, 32'h0);
        tick(1);
        check("press_data_k6_readback", readdata, 32'h1);
        check("press_irq_k6", {31'b0, irq}, 32'h1);
        reg_read(3'd3, rd); check("press_capture", rd, 32'h1);
        reg_write(3'd3, 32'h1);
        check("press_clear_irq", {31'b0, irq}, 32'h0);
        reg_read(3'd3, rd); check("press_clear_capture", rd, 32'h0);

        // Glitch of 3 cycles is dropped; 4-cycle pulse is accepted.
        in_port = 4'h3;
        tick(3);
        in_port = 4'h1;
        tick(10);
        reg_read(3'd0, rd); check("glitch_data", rd, 32'h1);
        reg_read(3'd1, rd); check("glitch_raw", rd, 32'h1);
        reg_read(3'd3, rd); check("glitch_capture", rd, 32'h0);
        in_port = 4'h3;
        tick(4);
        in_port = 4'h1;
        tick(12);
        reg_read(3'd0, rd); check("pulse4_data", rd, 32'h1);
        reg_read(3'd3, rd); check("pulse4_capture", rd, 32'h2);
        check("pulse4_irq_masked", {31'b0, irq}, 32'h0);
        reg_write(3'd3, 32'h2);

        // Falling-edge only on channel 2.
        reg_write(3'd4, 32'h0);
        reg_write(3'd5, 32'h4);
        in_port = 4'h5;
        tick(10);
        reg_read(3'd3, rd); check("fall_only_press", rd, 32'h0);
        in_port = 4'h1;
        tick(10);
        reg_read(3'd3, rd); check("fall_only_release", rd, 32'h4);

        // Build capture = 0xB, then partial and full W1C.
        reg_write(3'd3, 32'h4);
        reg_write(3'd4, 32'hF);
        reg_write(3'd5, 32'h0);
        in_port = 4'hA;
        tick(10);
        in_port = 4'hB;
        tick(10);
        reg_read(3'd3, rd); check("w1c_setup", rd, 32'hB);
        reg_write(3'd3, 32'h2);
        reg_read(3'd3, rd); check("w1c_partial", rd, 32'h9);
        reg_write(3'd2, 32'hF);
        check("w1c_irq_high", {31'b0, irq}, 32'h1);
        reg_write(3'd3, 32'h9);
        check("w1c_irq_low", {31'b0, irq}, 32'h0);
        reg_read(3'd3, rd); check("w1c_full", rd, 32'h0);

        // Clear of bit3 lands on the same edge that captures a new bit3 rise.
        reg_write(3'd5, 32'h8);
        in_port = 4'h3;
        tick(10);
        reg_read(3'd3, rd); check("simul_fall_capture", rd, 32'h8);
        in_port = 4'hB;
        tick(6);
        reg_write(3'd3, 32'h8);
        check("simul_irq", {31'b0, irq}, 32'h1);
        reg_read(3'd3, rd); check("simul_capture", rd, 32'h8);
        reg_write(3'd3, 32'h8);
        check("simul_later_clear", {31'b0, irq}, 32'h0);

        // Reset in the middle of a debounce count.
        address = 3'd4;
        in_port = 4'hF;
        tick(3);
        check("pre_reset_readdata", readdata, 32'hF);
        reset = 1'b1;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        in_port = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(10);
        reg_read(3'd3, rd); check("midreset_capture", rd, 32'h0);
        reg_read(3'd0, rd); check("midreset_data", rd, 32'h0);
        reg_read(3'd2, rd); check("midreset_mask", rd, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);

        // Input held high through reset release is seen as a fresh rising edge.
        in_port = 4'h1;
        reset   = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        reg_read(3'd0, rd); check("fresh_edge_data", rd, 32'h1);
        reg_read(3'd3, rd); check("fresh_edge_capture", rd, 32'h1);
        check("fresh_edge_irq_masked", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
